// File: rtl/apb_master_bridge_pkg.sv
// Shared types and helpers for the APB master bridge: FSM state encoding and
// wait-counter sizing.
package apb_master_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apbState_e;

  // Counter must be able to hold TIMEOUT itself; never narrower than one bit.
  function automatic int unsigned waitCntWidth(input int unsigned timeout);
    int unsigned w;
    w = (timeout == 0) ? 1 : $clog2(timeout + 1);
    return w;
  endfunction

endpackage

// File: rtl/apb_master_bridge_timeout_cnt.sv
// Saturating ACCESS wait counter; flags the stalled cycle that would bring the
// count up to TIMEOUT so the FSM can abort on that same edge.
module apb_timeout_cnt
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = waitCntWidth(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge pclk) begin
    if (preset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_noTimeout
      assign o_expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_W:0] LIMIT = (CNT_W+1)'(TIMEOUT);
      logic [CNT_W:0] w_countInc;
      assign w_countInc = {1'b0, r_count} + {{CNT_W{1'b0}}, 1'b1};
      assign o_expired  = i_enable && (w_countInc >= LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: accepts valid/ready commands, runs SETUP/ACCESS transfers and
// reports each result as a single-cycle response pulse.
module apb_master_bridge
  import apb_master_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apbState_e         r_state;
  apbState_e         w_nextState;
  logic              w_accept;
  logic              w_complete;
  logic              w_abort;
  logic              w_expired;
  logic              r_psel;
  logic              r_penable;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rspValid;
  logic [DATA_W-1:0] r_rspRdata;
  logic              r_rspErr;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeoutCnt (
    .pclk      (pclk),
    .preset    (preset),
    .i_clear   (r_state == ST_SETUP),
    .i_enable  ((r_state == ST_ACCESS) && !pready),
    .o_expired (w_expired)
  );

  always_comb begin
    w_nextState = ST_IDLE;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_nextState = ST_SETUP;
        end
      end
      ST_SETUP: w_nextState = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          w_complete = 1'b1;
        end else if (w_expired) begin
          w_abort = 1'b1;
        end else begin
          w_nextState = ST_ACCESS;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Bus controls are computed from the next state so they leave the flops
  // already aligned with the phase they belong to.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= ST_IDLE;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_rspValid <= 1'b0;
      r_rspRdata <= '0;
      r_rspErr   <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_psel     <= (w_nextState == ST_SETUP) || (w_nextState == ST_ACCESS);
      r_penable  <= (w_nextState == ST_ACCESS);
      r_rspValid <= w_complete || w_abort;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_wdata;
      end
      if (w_complete) begin
        r_rspErr   <= pslverr;
        r_rspRdata <= (!r_pwrite && !pslverr) ? prdata : '0;
      end else if (w_abort) begin
        r_rspErr   <= 1'b1;
        r_rspRdata <= '0;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rspValid;
  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_rspErr;

endmodule
